// File: rtl/hazard_sequencer_pkg.sv
// Shared core definitions: PCsrc encodings used by the decode controller and
// the hazard sequencer, plus the sequencer state type.
package hazard_sequencer_pkg;

   // PCsrc field of the registered decode control word
   localparam logic [3:0] PCSRC_SEQ = 4'b0000;
   localparam logic [3:0] PCSRC_JR  = 4'b0001;
   localparam logic [3:0] PCSRC_BR  = 4'b0010;
   localparam logic [3:0] PCSRC_J   = 4'b0101;
   localparam logic [3:0] PCSRC_JAL = 4'b1101;

   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StMemWait,
      StHalt
   } hz_state_e;

endpackage

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer: resolves load-use hazards, branch/jump
// redirects and data-memory wait states, and halts the core when data memory
// fails to respond within MEM_TIMEOUT frozen cycles.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic [3:0]  ex_pcsrc,
   input  logic        ex_br_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        memwb_flush,
   output logic        mem_timeout,
   output logic [15:0] stall_cycles
);

   localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

   hz_state_e       state_q, state_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            mem_timeout_q, mem_timeout_d;
   logic [15:0]     stall_q, stall_d;

   logic freeze, redirect, loaduse;

   // Hazard conditions
   always_comb begin
      freeze   = ((state_q == StRun) && mem_req && !mem_ready) ||
                 ((state_q == StMemWait) && !mem_ready);
      redirect = ex_pcsrc[0] || ((ex_pcsrc == PCSRC_BR) && ex_br_taken);
      loaduse  = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

   // Strobes: BOOT/HALT fixed, otherwise freeze > redirect > loaduse > normal
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (state_q == StBoot) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (state_q == StHalt || freeze) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (redirect) begin
         // Two bubbles; also kills any load-use dependent sitting in ID
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (loaduse) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // Next state, wait counter, sticky timeout and saturating stall count
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      stall_d       = stall_q;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            wait_cnt_d = '0;
            if (freeze) begin
               state_d    = StMemWait;
               wait_cnt_d = CntW'(1);
            end
         end
         StMemWait: begin
            if (!freeze) begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WaitLast) begin
               state_d       = StHalt;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StBoot;
      endcase
      if ((state_q == StRun || state_q == StMemWait) && !pc_en && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Registered state, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StBoot;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_q       <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_q       <= stall_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline stall/flush sequencer for the 5-stage MIPS core. It watches the ID, EX and MEM stages and drives the enable and flush strobes of the PC and the four pipeline registers. It resolves load-use hazards, branch/jump redirects and data-memory wait states, and halts the core on a memory timeout. It sits beside the decode controller and consumes that controller's registered PCsrc/MemRead/MemWrite/RegWrite fields.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive frozen cycles waiting on data memory before HALT (≥2).
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as an operand (R-type, beq, bne, sw).
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  5  destination (rt) of the EX load.
- ex_pcsrc  in  4  PCsrc of the EX instruction: 0000 seq, 0001 jr, 0010 branch, 0101 j, 1101 jal.
- ex_br_taken  in  1  ALU branch condition true in EX.
- mem_req  in  1  MEM instruction has MemRead or MemWrite set.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all-zero control); overrides enable.
- mem_timeout  out  1  sticky error, set on entry to HALT.
- stall_cycles  out  16  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT.

## Operation
- States: BOOT, RUN, MEM_WAIT, HALT. Reset enters BOOT.
- BOOT, one cycle: pc_en=0, all enables 0, all flushes 1. Next state is RUN.
- Conditions, evaluated combinationally:
  - freeze = (RUN & mem_req & ~mem_ready) | (MEM_WAIT & ~mem_ready).
  - redirect = ex_pcsrc[0] | (ex_pcsrc==0010 & ex_br_taken).
  - loaduse = ex_memread & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Priority order is freeze > redirect > loaduse > normal.
  - Freeze: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_flush=1. A redirect or load-use seen during freeze is not acted on; it is re-evaluated when the freeze lifts, because EX is held.
  - Redirect: all enables 1; ifid_flush=1, idex_flush=1. This gives 2 bubbles and also kills any load-use dependent in ID.
  - Load-use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. This gives exactly 1 bubble.
  - Normal: all enables 1, all flushes 0.
- State transitions:
  - RUN→MEM_WAIT on freeze.
  - MEM_WAIT→RUN in the cycle mem_ready=1. That cycle is not frozen and outputs follow redirect/loaduse/normal.
  - MEM_WAIT→HALT when a frozen cycle occurs with wait_cnt==MEM_TIMEOUT-1.
- wait_cnt ($clog2(MEM_TIMEOUT+1) bits):
  - Cleared in RUN.
  - Increments on each frozen cycle, including the RUN cycle that triggers the freeze.
  - At most MEM_TIMEOUT frozen cycles occur before HALT.
- HALT: outputs as freeze; mem_timeout=1. Only reset exits HALT.
- stall_cycles increments when pc_en=0 in RUN or MEM_WAIT. It holds at 0xFFFF and is not counted in BOOT or HALT.

## Timing
- State, wait_cnt, mem_timeout and stall_cycles are registered on clk rising edge. All are asynchronously cleared on reset_n low.
- Strobe outputs are combinational from state and current inputs, with zero latency, so they act at the next edge.
- Output values while reset_n is low: pc_en, ifid_en, idex_en and exmem_en are 0; all flushes are 1; mem_timeout=0; stall_cycles=0.
- Reset asserted mid-freeze or in HALT: on release the block always goes to BOOT, then RUN. No pending redirect is kept.
- mem_ready=1 with mem_req=0 is ignored in RUN.
- mem_ready going high on the MEM_TIMEOUT-th frozen cycle: not possible, since ready in MEM_WAIT means that cycle is unfrozen. No HALT.

## Structure
- Shared core package holds:
  - PCsrc constants (PCSRC_SEQ, PCSRC_JR, PCSRC_BR, PCSRC_J, PCSRC_JAL), shared with the decode controller.
  - hazard state enum.
- No sub-module. The saturating counter stays inline.

## Test plan
- Load-use: EX lw ex_rt=8, ID add id_rs=8. Required: exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal. ex_rt=0 gives no stall.
- Redirect: ex_pcsrc=0010 with ex_br_taken=1 → ifid_flush=idex_flush=1 for one cycle. With ex_br_taken=0 → no flush. ex_pcsrc=1101 → flush regardless of ex_br_taken.
- Redirect plus load-use in the same cycle: redirect flush only, pc_en=1, no stall cycle counted.
- Memory wait: mem_req=1, mem_ready low for 3 cycles. Required: 3 frozen cycles with memwb_flush=1, stall_cycles=3, resume when ready rises. A pending redirect flushes on the resume cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held low → 4 frozen cycles, then HALT with mem_timeout=1. Stays halted until reset_n pulses; then one BOOT cycle with all flushes 1, then RUN.
- Saturation: force 70000 load-use stalls → stall_cycles holds 0xFFFF.
